// File: rtl/input_skew_feeder.sv
// input_skew_feeder: streams a block of buffer rows and skews them into a
// diagonal byte wavefront, lane i delayed i cycles behind lane 0.
module input_skew_feeder #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int AW    = 5
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         len,
    output logic                busy,
    output logic                done,
    output logic                buf_cen,
    output logic [AW-1:0]       buf_a,
    input  logic [LANES*DW-1:0] buf_q,
    output logic [LANES*DW-1:0] lane_data,
    output logic [LANES-1:0]    lane_valid
);
    localparam logic [AW:0] DEPTH   = (AW+1)'(1 << AW);
    localparam logic [AW:0] DRAIN_N = (AW+1)'(LANES);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [AW:0]         r_cnt, w_len;
    logic [AW-1:0]       r_addr;
    logic                r_rd_tag, r_out_tag;
    logic [LANES*DW-1:0] r_out;

    assign w_len = (len > DEPTH) ? DEPTH : len;

    always_ff @(posedge CLK) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (w_len == '0) ? DONE : READ;
            READ:    if (r_cnt == (AW+1)'(1)) w_state_nxt = DRAIN;
            DRAIN:   if (r_cnt == '0) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        busy    = r_state != IDLE;
        done    = r_state == DONE;
        buf_cen = r_state != READ;
        buf_a   = (r_state == READ) ? r_addr : '0;
    end

    // Drain loads LANES and counts down through zero: LANES+1 cycles.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt  <= '0;
            r_addr <= '0;
        end else if (r_state == IDLE && start) begin
            r_cnt  <= w_len;
            r_addr <= base_addr;
        end else if (r_state == READ) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= (r_cnt == (AW+1)'(1)) ? DRAIN_N : r_cnt - 1'b1;
        end else if (r_state == DRAIN) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rd_tag  <= 1'b0;
            r_out_tag <= 1'b0;
            r_out     <= '0;
        end else begin
            r_rd_tag  <= r_state == READ;
            r_out_tag <= r_rd_tag;
            r_out     <= buf_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign lane_valid[0]     = r_out_tag;
            assign lane_data[0 +: DW] = r_out_tag ? r_out[0 +: DW] : '0;
        end else begin : g_skew
            logic [DW-1:0] r_d [i];
            logic          r_v [i];
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    for (int j = 0; j < i; j++) begin
                        r_d[j] <= '0;
                        r_v[j] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= r_out[i*DW +: DW];
                    r_v[0] <= r_out_tag;
                    for (int j = 1; j < i; j++) begin
                        r_d[j] <= r_d[j-1];
                        r_v[j] <= r_v[j-1];
                    end
                end
            end
            assign lane_valid[i]       = r_v[i-1];
            assign lane_data[i*DW +: DW] = r_v[i-1] ? r_d[i-1] : '0;
        end
    end
endmodule

// File: tb/tb_input_skew_feeder.sv
// tb_input_skew_feeder: buffer model plus per-cycle scoreboard of the skewed
// wavefront, control outputs and reset behaviour.
module tb_input_skew_feeder;
    logic         CLK = 1'b0;
    logic         RESET, start;
    logic [4:0]   base_addr;
    logic [5:0]   len;
    logic         busy, done, buf_cen;
    logic [4:0]   buf_a;
    logic [127:0] buf_q = '0;
    logic [127:0] lane_data;
    logic [15:0]  lane_valid;

    logic [127:0] mem [32];

    typedef struct {
        int         lane;
        logic [7:0] b;
    } item_t;
    item_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    input_skew_feeder dut (
        .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .buf_cen(buf_cen), .buf_a(buf_a), .buf_q(buf_q),
        .lane_data(lane_data), .lane_valid(lane_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (!buf_cen) buf_q <= mem[buf_a];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Cycle 0 is the start cycle; rst_at>0 aborts the transfer with RESET low.
    task automatic run(input logic [4:0] b, input logic [5:0] l, input bit lock, input int rst_at);
        int eff, total, last;
        logic [127:0] exp_d;
        logic [15:0] exp_v;
        logic rd;
        item_t it;
        eff   = (l > 6'd32) ? 32 : int'(l);
        total = (eff == 0) ? 1 : eff + 18;
        last  = (rst_at > 0) ? rst_at + 3 : total;
        sb.delete();
        for (int c = 3; c <= eff + 17; c++)
            for (int i = 0; i < 16; i++) begin
                int k = c - 3 - i;
                if (k >= 0 && k < eff) sb.push_back('{i, mem[(int'(b) + k) % 32][i*8 +: 8]});
            end
        step();
        start = 1'b1; base_addr = b; len = l;
        chk("idle_ctl", {busy, done, buf_cen, buf_a, lane_valid}, {1'b0, 1'b0, 1'b1, 5'd0, 16'd0});
        chk("idle_data", lane_data, '0);
        for (int c = 1; c <= last; c++) begin
            step();
            start = lock;
            base_addr = lock ? 5'd7 : b;
            if (rst_at > 0 && c == rst_at) RESET = 1'b0;
            if (rst_at > 0 && c > rst_at) begin
                chk("rst_ctl", {busy, done, buf_cen, buf_a}, {1'b0, 1'b0, 1'b1, 5'd0});
                chk("rst_valid", lane_valid, '0);
                chk("rst_data", lane_data, '0);
            end else begin
                rd = c <= eff;
                chk("busy", busy, c <= total);
                chk("done", done, c == total);
                chk("buf_cen", buf_cen, !rd);
                chk("buf_a", buf_a, rd ? 5'((int'(b) + c - 1) % 32) : 5'd0);
                exp_v = '0;
                for (int i = 0; i < 16; i++) if (c >= 3 + i && c <= 2 + eff + i) exp_v[i] = 1'b1;
                chk("lane_valid", lane_valid, exp_v);
                exp_d = '0;
                for (int i = 0; i < 16; i++)
                    if (lane_valid[i]) begin
                        if (sb.size() == 0) chk("sb_empty", 1, 0);
                        else begin
                            it = sb.pop_front();
                            chk("sb_lane", it.lane, i);
                            exp_d[i*8 +: 8] = it.b;
                        end
                    end
                chk("lane_data", lane_data, exp_d);
            end
        end
        if (rst_at > 0) RESET = 1'b1;
        else chk("sb_drained", sb.size(), 0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        RESET = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        fill_random();
        repeat (3) step();
        chk("reset_ctl", {busy, done, buf_cen, buf_a, lane_valid}, {1'b0, 1'b0, 1'b1, 5'd0, 16'd0});
        chk("reset_data", lane_data, '0);
        RESET = 1'b1;
        step();
        for (int i = 0; i < 16; i++) mem[0][i*8 +: 8] = 8'(8'h01 + i);
        run(5'd0, 6'd1, 1'b0, 0);
        for (int r = 0; r < 32; r++) mem[r] = {16{8'(r)}};
        run(5'd5, 6'd32, 1'b0, 0);
        run(5'd5, 6'd40, 1'b0, 0);
        run(5'd0, 6'd0, 1'b0, 0);
        run(5'd0, 6'd4, 1'b1, 0);
        fill_random();
        run(5'd9, 6'd3, 1'b0, 0);
        run(5'd3, 6'd8, 1'b0, 6);
        run(5'd30, 6'd3, 1'b0, 0);
        start = 1'b0;
        repeat (2) step();
        chk("final_idle", {busy, done, buf_cen, lane_valid}, {1'b0, 1'b0, 1'b1, 16'd0});
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
